// File: rtl/remote_pkg.sv
// Shared types and constants for the remote-side command sequencer.
package remote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_CHECK     = 3'd4,
    ST_FIN       = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BADRESP = 2'b01;
  localparam logic [1:0] ERR_TMO     = 2'b10;

  localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;

  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_CAL   = 8'h06;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rsp_timer.sv
// Response timeout counter: clears outside the wait, counts while enabled,
// saturates instead of wrapping, and flags the cycle the count hits limit-1.
module rsp_timer
  import remote_pkg::*;
#(
  parameter int unsigned      TMO_W       = 24,
  parameter logic [TMO_W-1:0] TMO_CYC     = 24'd1_000_000,
  parameter logic [TMO_W-1:0] CAL_TMO_CYC = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic cal_sel_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] ONE = TMO_W'(1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] limit_s;

  assign limit_s   = cal_sel_i ? CAL_TMO_CYC : TMO_CYC;
  assign expired_o = en_i && (cnt_q == (limit_s - ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {TMO_W{1'b0}};
    end else if (clr_i) begin
      cnt_q <= {TMO_W{1'b0}};
    end else if (en_i && (cnt_q != {TMO_W{1'b1}})) begin
      cnt_q <= cnt_q + ONE;
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/remote_cmd_seq.sv
// Initiator-side command sequencer: sends one command, waits for the ack byte,
// retries on bad response or timeout. Optional stats: REMOTE_CMD_SEQ_STATS_EN.
module remote_cmd_seq
  import remote_pkg::*;
#(
  parameter int unsigned      TMO_W       = 24,
  parameter logic [TMO_W-1:0] TMO_CYC     = 24'd1_000_000,
  parameter logic [TMO_W-1:0] CAL_TMO_CYC = 24'd10_000_000,
  parameter logic [7:0]       CAL_OPC     = OPC_CAL,
  parameter logic [7:0]       ACK_BYTE    = ACK_BYTE_DEF,
  parameter int unsigned      MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [7:0]  cmd_in,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [1:0]  err_code,
  output logic [7:0]  resp_last,
  output logic        snd_cmd,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy,
  output logic [15:0] n_retry,
  output logic [15:0] n_tmo
);

  state_e      state_q;
  logic        busy_q, done_q, ok_q, snd_cmd_q, clr_q;
  logic [1:0]  err_q;
  logic [7:0]  resp_last_q, cmd_q, attempts_q;
  logic [15:0] data_q;

  logic tmo_exp_s, tmo_ev_s, bad_ev_s, retry_s;

  rsp_timer #(
    .TMO_W      (TMO_W),
    .TMO_CYC    (TMO_CYC),
    .CAL_TMO_CYC(CAL_TMO_CYC)
  ) u_rsp_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != ST_WAIT_RESP),
    .en_i     (state_q == ST_WAIT_RESP),
    .cal_sel_i(cmd_q == CAL_OPC),
    .expired_o(tmo_exp_s)
  );

  // A response on the expiry cycle takes priority over the timeout.
  assign tmo_ev_s = (state_q == ST_WAIT_RESP) && tmo_exp_s && !resp_rdy;
  assign bad_ev_s = (state_q == ST_CHECK) && (resp_last_q != ACK_BYTE);
  assign retry_s  = (tmo_ev_s || bad_ev_s) && (attempts_q < 8'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= ERR_NONE;
      resp_last_q <= 8'h00;
      snd_cmd_q   <= 1'b0;
      clr_q       <= 1'b0;
      cmd_q       <= 8'h00;
      data_q      <= 16'h0000;
      attempts_q  <= 8'd0;
    end else begin
      snd_cmd_q <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            cmd_q      <= cmd_in;
            data_q     <= data_in;
            ok_q       <= 1'b0;
            err_q      <= ERR_NONE;
            attempts_q <= 8'd0;
            busy_q     <= 1'b1;
            snd_cmd_q  <= 1'b1;
            state_q    <= ST_SEND;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SEND: state_q <= ST_WAIT_SENT;
        ST_WAIT_SENT: begin
          if (cmd_sent) begin
            state_q <= ST_WAIT_RESP;
          end else begin
            state_q <= ST_WAIT_SENT;
          end
        end
        ST_WAIT_RESP: begin
          if (resp_rdy) begin
            resp_last_q <= resp;
            clr_q       <= 1'b1;
            state_q     <= ST_CHECK;
          end else begin
            state_q <= ST_WAIT_RESP;
          end
        end
        ST_CHECK: begin
          if (resp_last_q == ACK_BYTE) begin
            ok_q    <= 1'b1;
            err_q   <= ERR_NONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_FIN;
          end else begin
            state_q <= ST_CHECK;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      // Failure events override the per-state next state chosen above.
      if (tmo_ev_s || bad_ev_s) begin
        if (retry_s) begin
          attempts_q <= attempts_q + 8'd1;
          snd_cmd_q  <= 1'b1;
          state_q    <= ST_SEND;
        end else begin
          ok_q    <= 1'b0;
          err_q   <= tmo_ev_s ? ERR_TMO : ERR_BADRESP;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_FIN;
        end
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign ok           = ok_q;
  assign err_code     = err_q;
  assign resp_last    = resp_last_q;
  assign snd_cmd      = snd_cmd_q;
  assign clr_resp_rdy = clr_q;
  assign cmd          = cmd_q;
  assign data         = data_q;

`ifdef REMOTE_CMD_SEQ_STATS_EN
  logic [15:0] n_retry_q, n_tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_retry_q <= 16'h0000;
      n_tmo_q   <= 16'h0000;
    end else begin
      n_retry_q <= retry_s  ? sat_inc16(n_retry_q) : n_retry_q;
      n_tmo_q   <= tmo_ev_s ? sat_inc16(n_tmo_q)   : n_tmo_q;
    end
  end

  assign n_retry = n_retry_q;
  assign n_tmo   = n_tmo_q;
`else
  assign n_retry = 16'h0000;
  assign n_tmo   = 16'h0000;
`endif

endmodule

// File: tb/tb_remote_cmd_seq.sv
// Directed bench for remote_cmd_seq with a behavioural RemoteComm model.
module tb_remote_cmd_seq;

  logic        clk, rst, go;
  logic [7:0]  cmd_in;
  logic [15:0] data_in;
  logic        busy, done, ok, snd_cmd, clr_resp_rdy;
  logic [1:0]  err_code;
  logic [7:0]  resp_last, cmd, resp;
  logic [15:0] data, n_retry, n_tmo;
  logic        cmd_sent, resp_rdy;

`ifdef REMOTE_CMD_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  remote_cmd_seq #(
    .TMO_W(24), .TMO_CYC(24'd1000), .CAL_TMO_CYC(24'd5000), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .cmd_in(cmd_in), .data_in(data_in),
    .busy(busy), .done(done), .ok(ok), .err_code(err_code),
    .resp_last(resp_last), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .clr_resp_rdy(clr_resp_rdy), .n_retry(n_retry), .n_tmo(n_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // RemoteComm model: cmd_sent 3 cycles after snd_cmd, then response after a per-attempt delay (-1 = never).
  int         cyc, ph, cnt, idx, snd_cnt, clr_cnt;
  int         sent_t[0:3], snd_t[0:3], dly_tab[0:3];
  logic [7:0] rsp_tab[0:3];

  initial begin
    cmd_sent = 1'b0; resp_rdy = 1'b0; resp = 8'h00;
    cyc = 0; ph = 0; cnt = 0; idx = 0; snd_cnt = 0; clr_cnt = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      cmd_sent = 1'b0;
      if (clr_resp_rdy) clr_cnt++;
      if (snd_cmd) begin
        idx = (snd_cnt < 3) ? snd_cnt : 3;
        snd_t[idx] = cyc;
        snd_cnt++;
        ph = 1; cnt = 2;
      end else begin
        case (ph)
          1: if (cnt == 0) begin
               cmd_sent = 1'b1; sent_t[idx] = cyc; ph = 2; cnt = dly_tab[idx];
             end else cnt--;
          2: if (cnt == 0) begin
               resp = rsp_tab[idx]; resp_rdy = 1'b1; ph = 3;
             end else if (cnt > 0) cnt--;
          3: if (clr_resp_rdy) begin resp_rdy = 1'b0; ph = 0; end
          default: ;
        endcase
      end
    end
  end

  task automatic set_model(input int d0, d1, d2, input logic [7:0] r0, r1, r2);
    dly_tab[0] = d0; dly_tab[1] = d1; dly_tab[2] = d2; dly_tab[3] = -1;
    rsp_tab[0] = r0; rsp_tab[1] = r1; rsp_tab[2] = r2; rsp_tab[3] = 8'h00;
    snd_cnt = 0; clr_cnt = 0;
  endtask

  task automatic start_go(input logic [7:0] op, input logic [15:0] d);
    @(negedge clk);
    go = 1'b1; cmd_in = op; data_in = d;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check_vec("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_res(input string tag, input int exp_snd, input logic exp_ok,
                           input logic [1:0] exp_err, input logic [7:0] exp_last, input int exp_clr);
    check_vec({tag, "_snd"},  snd_cnt, exp_snd);
    check_vec({tag, "_ok"},   {31'd0, ok}, {31'd0, exp_ok});
    check_vec({tag, "_err"},  {30'd0, err_code}, {30'd0, exp_err});
    check_vec({tag, "_last"}, {24'd0, resp_last}, {24'd0, exp_last});
    check_vec({tag, "_clr"},  clr_cnt, exp_clr);
    check_vec({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_stats(input string tag, input int exp_r, input int exp_t);
    check_vec({tag, "_nretry"}, {16'd0, n_retry}, STATS ? exp_r : 0);
    check_vec({tag, "_ntmo"},   {16'd0, n_tmo},   STATS ? exp_t : 0);
  endtask

  task automatic run(input string tag, input logic [7:0] op, input int d0, d1, d2,
                     input logic [7:0] r0, r1, r2);
    set_model(d0, d1, d2, r0, r1, r2);
    start_go(op, 16'hBEEF);
    wait_done(20000);
  endtask

  int dn;

  initial begin
    rst = 1'b1; go = 1'b0; cmd_in = 8'h00; data_in = 16'h0000;
    repeat (3) @(negedge clk);
    check_vec("rst_ctl", {25'd0, busy, done, ok, err_code, snd_cmd, clr_resp_rdy}, 32'd0);
    check_vec("rst_cmd", {cmd, resp_last, data}, 32'd0);
    check_vec("rst_stats", {n_retry, n_tmo}, 32'd0);
    rst = 1'b0;

    // Happy path with launch timing
    set_model(5, -1, -1, 8'hA5, 8'h00, 8'h00);
    start_go(8'h02, 16'h1234);
    check_vec("go_busy", {31'd0, busy}, 32'd1);
    check_vec("go_snd", {31'd0, snd_cmd}, 32'd1);
    check_vec("go_cmd", {24'd0, cmd}, 32'h02);
    check_vec("go_data", {16'd0, data}, 32'h1234);
    @(negedge clk);
    check_vec("snd_1cyc", {31'd0, snd_cmd}, 32'd0);
    wait_done(20000);
    check_res("happy", 1, 1'b1, 2'b00, 8'hA5, 1);
    check_stats("happy", 0, 0);
    @(negedge clk);
    check_vec("done_1cyc", {31'd0, done}, 32'd0);

    run("badack", 8'h02, 5, 5, -1, 8'h5A, 8'hA5, 8'h00);
    check_res("badack", 2, 1'b1, 2'b00, 8'hA5, 2);
    check_stats("badack", 1, 0);

    run("alltmo", 8'h02, -1, -1, -1, 8'h00, 8'h00, 8'h00);
    check_res("alltmo", 3, 1'b0, 2'b10, 8'hA5, 0);
    check_vec("tmo_gap0", snd_t[1] - sent_t[0], 1001);
    check_vec("tmo_gap1", snd_t[2] - sent_t[1], 1001);
    check_stats("alltmo", 3, 3);

    run("cal3000", 8'h06, 3000, -1, -1, 8'hA5, 8'h00, 8'h00);
    check_res("cal3000", 1, 1'b1, 2'b00, 8'hA5, 1);

    run("nrm3000", 8'h02, 3000, 5, -1, 8'hA5, 8'hA5, 8'h00);
    check_res("nrm3000", 2, 1'b1, 2'b00, 8'hA5, 1);
    check_stats("nrm3000", 4, 4);

    run("exp999", 8'h02, 999, -1, -1, 8'hA5, 8'h00, 8'h00);
    check_res("exp999", 1, 1'b1, 2'b00, 8'hA5, 1);

    run("exp1000", 8'h02, 1000, 5, -1, 8'hA5, 8'hA5, 8'h00);
    check_res("exp1000", 2, 1'b1, 2'b00, 8'hA5, 1);
    check_stats("exp1000", 5, 5);

    run("allbad", 8'h02, 5, 5, 5, 8'h5A, 8'h5A, 8'h5A);
    check_res("allbad", 3, 1'b0, 2'b01, 8'h5A, 3);
    check_stats("allbad", 7, 5);

    // go while busy, then go during the done cycle
    set_model(50, -1, -1, 8'hA5, 8'h00, 8'h00);
    start_go(8'h02, 16'h1111);
    repeat (5) @(negedge clk);
    go = 1'b1; cmd_in = 8'h33; data_in = 16'hFFFF;
    @(negedge clk);
    go = 1'b0;
    check_vec("busygo_cmd", {24'd0, cmd}, 32'h02);
    check_vec("busygo_data", {16'd0, data}, 32'h1111);
    wait_done(20000);
    check_res("busygo", 1, 1'b1, 2'b00, 8'hA5, 1);
    go = 1'b1; cmd_in = 8'h44;
    @(negedge clk);
    go = 1'b0;
    check_vec("fingo_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    check_vec("fingo_snd", snd_cnt, 1);
    check_vec("fingo_cmd", {24'd0, cmd}, 32'h02);

    // Reset during the second attempt's response wait
    set_model(-1, -1, -1, 8'h00, 8'h00, 8'h00);
    start_go(8'h02, 16'h2222);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (snd_cnt >= 2) break;
    end
    check_vec("mid_reach", snd_cnt, 2);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_vec("mid_busy", {31'd0, busy}, 32'd0);
    check_vec("mid_cmd", {cmd, resp_last, data}, 32'd0);
    check_stats("mid", 0, 0);
    dn = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_vec("mid_nodone", dn, 0);
    check_vec("mid_nosnd", snd_cnt, 2);

    run("postrst", 8'h02, -1, -1, 5, 8'h00, 8'h00, 8'hA5);
    check_res("postrst", 3, 1'b1, 2'b00, 8'hA5, 1);
    check_stats("postrst", 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
